// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_ctrl
// Purpose  : Loadable instruction memory for the RISC-V core. A program-load
//            port fills the array word by word while in LOAD; a registered,
//            handshaked fetch port serves the CPU front end while in RUN and
//            flags misaligned or out-of-range PCs. Loading and fetching are
//            mutually exclusive.
// Ports    : clk, reset_n           - clock, asynchronous active-low reset
//            prog_start/we/data/done - program-load controls
//            prog_ovf, load_count    - load status (sticky wrap, words written)
//            run_mode                - 1 while fetches are being served
//            fetch_req/addr/ready    - fetch request handshake
//            fetch_valid/instr/fault - fetch response, one cycle latency
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_ctrl #(
    parameter int                DEPTH     = 64,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = 'h0000_0013,
    parameter bit                BOOT_LOAD = 1'b1,
    localparam int               IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              prog_start,
    input  logic              prog_we,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_done,
    output logic              prog_ovf,
    output logic [IDX_W:0]    load_count,
    output logic              run_mode,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic [1:0]        fetch_fault
);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0]  c_last_idx   = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]    c_depth_cnt  = (IDX_W + 1)'(DEPTH);
    localparam logic [ADDR_W-3:0] c_depth_word = (ADDR_W - 2)'(DEPTH);

    localparam logic [1:0] c_fault_ok    = 2'b00;
    localparam logic [1:0] c_fault_align = 2'b01;
    localparam logic [1:0] c_fault_range = 2'b10;

    state_t            r_state;
    logic [IDX_W-1:0]  r_wr_ptr;
    logic [IDX_W:0]    r_load_count;
    logic              r_prog_ovf;
    logic              r_fetch_valid;
    logic [DATA_W-1:0] r_fetch_instr;
    logic [1:0]        r_fetch_fault;

    // No reset on the array: a loaded program must survive a core reset.
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_mem_we;
    logic              w_accept;
    logic [ADDR_W-3:0] w_word;
    logic [IDX_W-1:0]  w_idx;
    logic              w_in_range;

    assign w_mem_we   = prog_we && (r_state == ST_LOAD);
    assign w_accept   = fetch_req && (r_state == ST_RUN);
    assign w_word     = fetch_addr[ADDR_W-1:2];
    assign w_idx      = fetch_addr[IDX_W+1:2];
    // Full-width compare so non-power-of-two depths reject the gap between
    // DEPTH and 2**IDX_W instead of aliasing into the array.
    assign w_in_range = (w_word < c_depth_word);

    // ------------------------------------------------------------------
    // Load / run controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= BOOT_LOAD ? ST_LOAD : ST_RUN;
            r_wr_ptr     <= '0;
            r_load_count <= '0;
            r_prog_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (prog_we) begin
                        if (r_wr_ptr == c_last_idx) begin
                            r_wr_ptr   <= '0;
                            r_prog_ovf <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                        if (r_load_count != c_depth_cnt) begin
                            r_load_count <= r_load_count + 1'b1;
                        end
                    end
                    // A write in the same cycle still lands: the array write
                    // is driven independently of this transition.
                    if (prog_done) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (prog_start) begin
                        r_state      <= ST_LOAD;
                        r_wr_ptr     <= '0;
                        r_load_count <= '0;
                        r_prog_ovf   <= 1'b0;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= prog_data;
        end
    end

    // ------------------------------------------------------------------
    // Fetch response: a request seen in RUN is answered on the next edge,
    // including the cycle in which prog_start moves the block to LOAD.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_valid <= 1'b0;
            r_fetch_instr <= NOP_INSTR;
            r_fetch_fault <= c_fault_ok;
        end else begin
            r_fetch_valid <= w_accept;
            if (w_accept) begin
                if (fetch_addr[1:0] != 2'b00) begin
                    r_fetch_fault <= c_fault_align;
                    r_fetch_instr <= NOP_INSTR;
                end else if (!w_in_range) begin
                    r_fetch_fault <= c_fault_range;
                    r_fetch_instr <= NOP_INSTR;
                end else begin
                    r_fetch_fault <= c_fault_ok;
                    r_fetch_instr <= r_mem[w_idx];
                end
            end
        end
    end

    assign run_mode    = (r_state == ST_RUN);
    assign fetch_ready = run_mode;
    assign prog_ovf    = r_prog_ovf;
    assign load_count  = r_load_count;
    assign fetch_valid = r_fetch_valid;
    assign fetch_instr = r_fetch_instr;
    assign fetch_fault = r_fetch_fault;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_ctrl
// Purpose  : Self-checking bench for instr_mem_ctrl. Instance A (DEPTH=64,
//            boots into LOAD) is driven from a table of per-cycle vectors;
//            instance B (DEPTH=4, boots into RUN) gets hand-written sequences
//            for pointer wrap and reset in the middle of a fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_ctrl;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Instance A: DEPTH=64, BOOT_LOAD=1
    // ------------------------------------------------------------------
    logic        a_rst_n = 1'b0;
    logic        a_start = 1'b0, a_we = 1'b0, a_done = 1'b0, a_req = 1'b0;
    logic [31:0] a_data = '0, a_addr = '0;
    logic        a_ovf, a_run, a_ready, a_valid;
    logic [6:0]  a_cnt;
    logic [31:0] a_instr;
    logic [1:0]  a_fault;

    instr_mem_ctrl #(.DEPTH(64), .BOOT_LOAD(1'b1)) u_dut_a (
        .clk(clk), .reset_n(a_rst_n),
        .prog_start(a_start), .prog_we(a_we), .prog_data(a_data), .prog_done(a_done),
        .prog_ovf(a_ovf), .load_count(a_cnt), .run_mode(a_run),
        .fetch_req(a_req), .fetch_addr(a_addr), .fetch_ready(a_ready),
        .fetch_valid(a_valid), .fetch_instr(a_instr), .fetch_fault(a_fault)
    );

    // ------------------------------------------------------------------
    // Instance B: DEPTH=4, BOOT_LOAD=0
    // ------------------------------------------------------------------
    logic        b_rst_n = 1'b0;
    logic        b_start = 1'b0, b_we = 1'b0, b_done = 1'b0, b_req = 1'b0;
    logic [31:0] b_data = '0, b_addr = '0;
    logic        b_ovf, b_run, b_ready, b_valid;
    logic [2:0]  b_cnt;
    logic [31:0] b_instr;
    logic [1:0]  b_fault;

    instr_mem_ctrl #(.DEPTH(4), .BOOT_LOAD(1'b0)) u_dut_b (
        .clk(clk), .reset_n(b_rst_n),
        .prog_start(b_start), .prog_we(b_we), .prog_data(b_data), .prog_done(b_done),
        .prog_ovf(b_ovf), .load_count(b_cnt), .run_mode(b_run),
        .fetch_req(b_req), .fetch_addr(b_addr), .fetch_ready(b_ready),
        .fetch_valid(b_valid), .fetch_instr(b_instr), .fetch_fault(b_fault)
    );

    // One record per clock edge: inputs driven before the edge, outputs
    // expected just after it.
    typedef struct {
        logic        st, we;
        logic [31:0] data;
        logic        done, req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [1:0]  fault;
        logic        run;
        logic [6:0]  cnt;
        logic        ovf;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic st, logic we, logic [31:0] data, logic done,
                                logic req, logic [31:0] addr, logic valid,
                                logic [31:0] instr, logic [1:0] fault, logic run,
                                logic [6:0] cnt, logic ovf);
        vec_t v;
        v.st = st; v.we = we; v.data = data; v.done = done; v.req = req; v.addr = addr;
        v.valid = valid; v.instr = instr; v.fault = fault; v.run = run; v.cnt = cnt; v.ovf = ovf;
        return v;
    endfunction

    task automatic b_step(input logic st, input logic we, input logic [31:0] data,
                          input logic done, input logic req, input logic [31:0] addr);
        b_start = st; b_we = we; b_data = data; b_done = done; b_req = req; b_addr = addr;
        @(posedge clk);
        #1;
        b_start = 1'b0; b_we = 1'b0; b_done = 1'b0; b_req = 1'b0;
    endtask

    task automatic b_fetch_check(input string name, input logic [31:0] addr,
                                 input logic [31:0] instr, input logic [1:0] fault);
        b_step(1'b0, 1'b0, '0, 1'b0, 1'b1, addr);
        check({name, ".valid"}, {31'd0, b_valid}, 32'd1);
        check({name, ".instr"}, b_instr, instr);
        check({name, ".fault"}, {30'd0, b_fault}, {30'd0, fault});
    endtask

    initial begin
        // ---------------- table for instance A ----------------
        //              st  we  data          done req addr        | valid instr         flt  run cnt ovf
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0,        0, c_nop,        2'd0, 0, 7'd0, 0)); // fetch ignored in LOAD
        vq.push_back(mk(0, 1, 32'h00208AB3, 0, 0, 32'h0,        0, c_nop,        2'd0, 0, 7'd1, 0));
        vq.push_back(mk(0, 1, 32'h40418AB3, 0, 0, 32'h0,        0, c_nop,        2'd0, 0, 7'd2, 0));
        vq.push_back(mk(0, 1, 32'h00629AB3, 0, 0, 32'h0,        0, c_nop,        2'd0, 0, 7'd3, 0));
        vq.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        0, c_nop,        2'd0, 1, 7'd3, 0)); // prog_done
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0,        1, 32'h00208AB3, 2'd0, 1, 7'd3, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h4,        1, 32'h40418AB3, 2'd0, 1, 7'd3, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h8,        1, 32'h00629AB3, 2'd0, 1, 7'd3, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h00629AB3, 2'd0, 1, 7'd3, 0)); // hold
        vq.push_back(mk(0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h00629AB3, 2'd0, 1, 7'd3, 0)); // we ignored in RUN
        vq.push_back(mk(0, 0, 32'h0,        1, 1, 32'h6,        1, c_nop,        2'd1, 1, 7'd3, 0)); // misaligned
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h100,      1, c_nop,        2'd2, 1, 7'd3, 0)); // out of range
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h102,      1, c_nop,        2'd1, 1, 7'd3, 0)); // misalign wins
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0,        1, 32'h00208AB3, 2'd0, 1, 7'd3, 0)); // not overwritten
        vq.push_back(mk(1, 0, 32'h0,        0, 1, 32'h4,        1, 32'h40418AB3, 2'd0, 0, 7'd0, 0)); // start + fetch
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h8,        0, 32'h40418AB3, 2'd0, 0, 7'd0, 0)); // ignored
        vq.push_back(mk(1, 1, 32'h11111111, 0, 0, 32'h0,        0, 32'h40418AB3, 2'd0, 0, 7'd1, 0)); // start ignored
        vq.push_back(mk(0, 1, 32'h22222222, 1, 0, 32'h0,        0, 32'h40418AB3, 2'd0, 1, 7'd2, 0)); // we + done
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h4,        1, 32'h22222222, 2'd0, 1, 7'd2, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0,        1, 32'h11111111, 2'd0, 1, 7'd2, 0));

        // ---------------- resets ----------------
        #12;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        #1;
        check("a_reset.run_mode",   {31'd0, a_run},   32'd0);
        check("a_reset.ready",      {31'd0, a_ready}, 32'd0);
        check("a_reset.valid",      {31'd0, a_valid}, 32'd0);
        check("a_reset.instr",      a_instr,          c_nop);
        check("a_reset.fault",      {30'd0, a_fault}, 32'd0);
        check("a_reset.load_count", {25'd0, a_cnt},   32'd0);
        check("a_reset.ovf",        {31'd0, a_ovf},   32'd0);
        check("b_reset.run_mode",   {31'd0, b_run},   32'd1);
        check("b_reset.ready",      {31'd0, b_ready}, 32'd1);

        // ---------------- table-driven run on A ----------------
        @(posedge clk);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            a_start = vq[i].st; a_we = vq[i].we; a_data = vq[i].data;
            a_done = vq[i].done; a_req = vq[i].req; a_addr = vq[i].addr;
            @(posedge clk);
            #1;
            check($sformatf("a_vec%0d.valid", i), {31'd0, a_valid}, {31'd0, vq[i].valid});
            check($sformatf("a_vec%0d.instr", i), a_instr, vq[i].instr);
            check($sformatf("a_vec%0d.fault", i), {30'd0, a_fault}, {30'd0, vq[i].fault});
            check($sformatf("a_vec%0d.run", i),   {31'd0, a_run},   {31'd0, vq[i].run});
            check($sformatf("a_vec%0d.ready", i), {31'd0, a_ready}, {31'd0, vq[i].run});
            check($sformatf("a_vec%0d.cnt", i),   {25'd0, a_cnt},   {25'd0, vq[i].cnt});
            check($sformatf("a_vec%0d.ovf", i),   {31'd0, a_ovf},   {31'd0, vq[i].ovf});
        end
        a_start = 1'b0; a_we = 1'b0; a_done = 1'b0; a_req = 1'b0;

        // ---------------- B: wrap with DEPTH=4 ----------------
        b_step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        check("b_start.run_mode", {31'd0, b_run}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            b_step(1'b0, 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, '0);
            check($sformatf("b_load%0d.cnt", i), {29'd0, b_cnt}, (i < 3) ? 32'(i + 1) : 32'd4);
            check($sformatf("b_load%0d.ovf", i), {31'd0, b_ovf}, (i < 3) ? 32'd0 : 32'd1);
        end
        b_step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        check("b_done.run_mode", {31'd0, b_run}, 32'd1);
        b_fetch_check("b_f0",     32'h0,  32'hA000_0004, 2'd0);
        b_fetch_check("b_f4",     32'h4,  32'hA000_0001, 2'd0);
        b_fetch_check("b_fC",     32'hC,  32'hA000_0003, 2'd0);
        b_fetch_check("b_f10",    32'h10, c_nop,         2'd2);

        // ---------------- B: reset with a response pending ----------------
        b_step(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h8);
        check("b_pend.valid", {31'd0, b_valid}, 32'd1);
        check("b_pend.instr", b_instr, 32'hA000_0002);
        b_req = 1'b1; b_addr = 32'h4;
        b_rst_n = 1'b0;
        #1;
        check("b_rst.valid", {31'd0, b_valid}, 32'd0);
        check("b_rst.instr", b_instr, c_nop);
        check("b_rst.fault", {30'd0, b_fault}, 32'd0);
        check("b_rst.cnt",   {29'd0, b_cnt}, 32'd0);
        check("b_rst.ovf",   {31'd0, b_ovf}, 32'd0);
        b_req = 1'b0;
        @(posedge clk);
        #3;
        b_rst_n = 1'b1;
        #1;
        check("b_rel.run_mode", {31'd0, b_run}, 32'd1);
        check("b_rel.valid",    {31'd0, b_valid}, 32'd0);
        b_fetch_check("b_after_rst_f0", 32'h0, 32'hA000_0004, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Parametrised, loadable instruction memory for the RISC-V core. It replaces fixed initial-block program images with a runtime program-load port. A registered, handshaked fetch port serves the CPU front end and flags misaligned or out-of-range PCs. A two-state controller keeps loading and fetching mutually exclusive.

Parameters:
DEPTH, 64, number of instruction words; any value >= 2; IDX_W = $clog2(DEPTH)
DATA_W, 32, instruction width in bits
ADDR_W, 32, fetch byte-address width
NOP_INSTR, 32'h0000_0013, word returned on a faulted fetch (addi x0,x0,0)
BOOT_LOAD, 1, 1 = leave reset in LOAD state; 0 = leave reset in RUN state

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
prog_start  input  1  in RUN: enter LOAD and clear wr_ptr
prog_we  input  1  in LOAD: write prog_data to mem[wr_ptr], then increment wr_ptr
prog_data  input  DATA_W  program word
prog_done  input  1  in LOAD: go to RUN
prog_ovf  output  1  sticky; set when wr_ptr wraps
load_count  output  IDX_W+1  words written since last LOAD entry, saturates at DEPTH
run_mode  output  1  1 when state == RUN
fetch_req  input  1  fetch request
fetch_addr  input  ADDR_W  fetch byte address (PC)
fetch_ready  output  1  equals run_mode; request accepted when fetch_req && fetch_ready
fetch_valid  output  1  response valid
fetch_instr  output  DATA_W  fetched instruction
fetch_fault  output  2  00 ok, 01 misaligned, 10 out of range

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - state = LOAD if BOOT_LOAD else RUN
  - wr_ptr = 0, load_count = 0, prog_ovf = 0
  - fetch_valid = 0, fetch_instr = NOP_INSTR, fetch_fault = 00
  - Memory array is not cleared; contents survive reset.
- State LOAD:
  - fetch_ready = 0; fetch_req is ignored.
  - prog_we: mem[wr_ptr] <= prog_data; wr_ptr <= wr_ptr + 1; load_count increments, saturating at DEPTH.
  - If wr_ptr == DEPTH-1 when prog_we is seen: wr_ptr wraps to 0 and prog_ovf sets. Later writes overwrite from index 0.
  - prog_done moves state to RUN next cycle. prog_we and prog_done in the same cycle: the write completes, then RUN.
  - prog_start is ignored.
- State RUN:
  - fetch_ready = 1.
  - prog_we and prog_done are ignored.
  - prog_start moves state to LOAD and clears wr_ptr, load_count and prog_ovf.
  - prog_start and fetch_req in the same cycle: the fetch is accepted and its response is still delivered next cycle; the state is LOAD from the next cycle onward.
- Fetch latency is exactly 1 cycle. For a request accepted at edge N, fetch_valid/fetch_instr/fetch_fault are registered at edge N+1.
  - fetch_valid = 1 for one cycle per accepted request.
  - Back-to-back requests give back-to-back responses at full throughput; there is no backpressure on the response.
- Fault checks on the registered request, in priority order:
  - fetch_addr[1:0] != 0 -> fault 01, instr = NOP_INSTR
  - else fetch_addr[ADDR_W-1:2] >= DEPTH -> fault 10, instr = NOP_INSTR
  - else fault 00, instr = mem[fetch_addr[IDX_W+1:2]]
- When no request is accepted, fetch_valid = 0 and fetch_instr/fetch_fault hold their last values.
- Reset asserted mid-load or mid-fetch: pending response is dropped (fetch_valid = 0); words already written stay in memory.
- Non-power-of-two DEPTH: range check uses the full compare above, not index truncation.

Test Plan:
1. BOOT_LOAD=1, reset release: fetch_req with addr 0 -> fetch_ready=0, no fetch_valid. Load 0x00208AB3, 0x40418AB3, 0x00629AB3, then prog_done -> load_count=3, run_mode=1 next cycle.
2. RUN, fetch_req at addr 0,4,8 on consecutive cycles -> fetch_valid high 3 cycles, starting one cycle after the first request, instr = 0x00208AB3, 0x40418AB3, 0x00629AB3, fault 00.
3. Fetch addr 0x6 -> fault 01, instr 0x00000013. Fetch addr 0x100 with DEPTH=64 -> fault 10, instr 0x00000013.
4. DEPTH=4, write 5 words W0..W4 -> prog_ovf=1, load_count=4, mem[0]=W4. After prog_done, fetch addr 0 -> W4.
5. prog_start in the same cycle as fetch_req addr 4 -> response delivered next cycle with mem[1]; run_mode=0; the following fetch_req is ignored.
6. Assert reset_n=0 mid-stream with fetch_valid pending -> fetch_valid=0 immediately. With BOOT_LOAD=0, after release fetch addr 0 -> previously loaded word returned.
